// File: rtl/mod_exp_engine_pkg.sv
// rtl/mod_exp_engine_pkg.sv - shared width default and sequencer state encoding for the mod-exp handshake
package mod_exp_engine_pkg;

    localparam int DEFAULT_WIDTH = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_UPD  = 2'd2
    } state_t;

endpackage

// File: rtl/mod_exp_engine_if.sv
// rtl/mod_exp_engine_if.sv - control <-> mod-exp request/response handshake bundle
interface mod_exp_engine_if
    import mod_exp_engine_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int EXP_WIDTH = WIDTH
);
    logic                 start;
    logic [WIDTH-1:0]     base;
    logic [EXP_WIDTH-1:0] exponent;
    logic [WIDTH-1:0]     modulus;
    logic [WIDTH-1:0]     result;
    logic                 busy;
    logic                 mod_exp_finish;
    logic                 err;

    modport master (
        output start, base, exponent, modulus,
        input  result, busy, mod_exp_finish, err
    );

    modport slave (
        input  start, base, exponent, modulus,
        output result, busy, mod_exp_finish, err
    );
endinterface

// File: rtl/mod_mul_serial.sv
// rtl/mod_mul_serial.sv - bit-serial interleaved a*x mod n, one multiplier bit per cycle while go is high
module mod_mul_serial
    import mod_exp_engine_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] prod,
    output logic             done
);
    localparam int AW = WIDTH + 2;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_base;
    logic [AW-1:0]    dbl;
    logic [AW-1:0]    dbl_red;
    logic [AW-1:0]    sum;
    logic [AW-1:0]    sum_red;
    logic [AW-1:0]    n_ext;
    logic [AW-1:0]    x_ext;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             first;
    logic             bit_cur;

    // The first step restarts from acc=0 and takes the multiplier MSB directly,
    // so a run of go costs exactly WIDTH cycles with no separate load cycle.
    always_comb begin
        first    = (cnt == '0);
        n_ext    = {2'b00, n};
        x_ext    = {2'b00, x};
        acc_base = first ? '0 : acc;
        bit_cur  = first ? a[WIDTH-1] : shreg[WIDTH-1];
        dbl      = acc_base << 1;
        dbl_red  = (dbl >= n_ext) ? dbl - n_ext : dbl;
        sum      = bit_cur ? dbl_red + x_ext : dbl_red;
        sum_red  = (sum >= n_ext) ? sum - n_ext : sum;
        done     = go && (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            shreg <= '0;
            cnt   <= '0;
        end else if (go) begin
            acc   <= sum_red;
            shreg <= first ? (a << 1) : (shreg << 1);
            cnt   <= (cnt == CW'(WIDTH - 1)) ? '0 : cnt + CW'(1);
        end
    end

    assign prod = acc[WIDTH-1:0];
endmodule

// File: rtl/mod_exp_engine.sv
// rtl/mod_exp_engine.sv - right-to-left square-and-multiply modular exponentiation responder
module mod_exp_engine
    import mod_exp_engine_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int EXP_WIDTH = WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    mod_exp_engine_if.slave   bus
);
    localparam int BW = $clog2(EXP_WIDTH) + 1;

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     r;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     n;
    logic [EXP_WIDTH-1:0] e;
    logic [BW-1:0]        bitcnt;
    logic [WIDTH-1:0]     result_q;
    logic                 busy_q;
    logic                 finish_q;
    logic                 err_q;
    logic [WIDTH-1:0]     prod_a;
    logic [WIDTH-1:0]     prod_b;
    logic [WIDTH-1:0]     r_next;
    logic                 done_a;
    logic                 done_b;
    logic                 illegal;
    logic                 accept;
    logic                 reject;
    logic                 mul_go;
    logic                 upd;
    logic                 last_bit;

    assign illegal = (bus.modulus < WIDTH'(2)) || (bus.base >= bus.modulus);
    assign r_next  = e[0] ? prod_a : r;

    mod_mul_serial #(.WIDTH(WIDTH)) u_mul_a (
        .clk(clk), .reset(reset), .go(mul_go),
        .a(r), .x(b), .n(n), .prod(prod_a), .done(done_a)
    );

    mod_mul_serial #(.WIDTH(WIDTH)) u_mul_b (
        .clk(clk), .reset(reset), .go(mul_go),
        .a(b), .x(b), .n(n), .prod(prod_b), .done(done_b)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.start && !illegal) state_next = ST_MUL;
            ST_MUL:  if (done_a && done_b)      state_next = ST_UPD;
            ST_UPD:  state_next = last_bit ? ST_IDLE : ST_MUL;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        accept   = (state == ST_IDLE) && bus.start && !illegal;
        reject   = (state == ST_IDLE) && bus.start && illegal;
        mul_go   = (state == ST_MUL);
        upd      = (state == ST_UPD);
        last_bit = (bitcnt == BW'(EXP_WIDTH - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r        <= '0;
            b        <= '0;
            n        <= '0;
            e        <= '0;
            bitcnt   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            finish_q <= 1'b0;
            if (accept) begin
                r      <= WIDTH'(1);
                b      <= bus.base;
                n      <= bus.modulus;
                e      <= bus.exponent;
                bitcnt <= '0;
                busy_q <= 1'b1;
                err_q  <= 1'b0;
            end
            if (reject) begin
                result_q <= '0;
                err_q    <= 1'b1;
                finish_q <= 1'b1;
            end
            if (upd) begin
                r      <= r_next;
                b      <= prod_b;
                e      <= e >> 1;
                bitcnt <= bitcnt + BW'(1);
                if (last_bit) begin
                    result_q <= r_next;
                    finish_q <= 1'b1;
                    busy_q   <= 1'b0;
                end
            end
        end
    end

    assign bus.result         = result_q;
    assign bus.busy           = busy_q;
    assign bus.mod_exp_finish = finish_q;
    assign bus.err            = err_q;
endmodule
